// File: rtl/vec_mul_pkg.sv
// Shared types, sizes and helper functions for the vector multiplier operand path.
package vec_mul_pkg;

    localparam int unsigned VLEN       = 128;
    localparam int unsigned LANE_W     = 32;
    localparam int unsigned VLEN_B     = VLEN / 8;
    localparam int unsigned LANE_B     = LANE_W / 8;
    localparam int unsigned LB_W       = $clog2(LANE_B);
    localparam int unsigned VL_W       = $clog2(VLEN_B) + 1;
    localparam int unsigned NBEATS_MAX = VLEN / LANE_W;
    localparam int unsigned K_W        = (NBEATS_MAX > 1) ? $clog2(NBEATS_MAX) : 1;
    localparam int unsigned NB_W       = $clog2(NBEATS_MAX) + 1;

    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10
    } sew_e;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } seq_state_e;

    // Maximum element count for a SEW; zero for the illegal encoding.
    function automatic logic [VL_W-1:0] vlmax(input logic [1:0] sew);
        case (sew)
            SEW8:    vlmax = VL_W'(VLEN_B);
            SEW16:   vlmax = VL_W'(VLEN_B / 2);
            SEW32:   vlmax = VL_W'(VLEN_B / 4);
            default: vlmax = '0;
        endcase
    endfunction

    // Beats needed to carry vle elements: ceil(bytes / lane bytes).
    function automatic logic [NB_W-1:0] beats(input logic [VL_W-1:0] vle,
                                              input logic [1:0] sew);
        logic [VL_W+1:0] nbytes;
        nbytes = (VL_W+2)'(vle) << sew;
        beats  = NB_W'((nbytes + (VL_W+2)'(LANE_B - 1)) >> LB_W);
    endfunction

endpackage

// File: rtl/sew_operand_sequencer_if.sv
// Operand-in / beat-out handshake bundle for the operand sequencer.
interface sew_operand_sequencer_if;
    import vec_mul_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        sew;
    logic [VL_W-1:0]   vl;
    logic [VLEN-1:0]   data_A;
    logic [VLEN-1:0]   data_B;
    logic              out_valid;
    logic              out_ready;
    logic [LANE_W-1:0] out_A;
    logic [LANE_W-1:0] out_B;
    logic [LANE_B-1:0] out_be;
    logic              out_last;
    logic [1:0]        out_sew;
    logic              err;

    modport master (
        output in_valid, sew, vl, data_A, data_B, out_ready,
        input  in_ready, out_valid, out_A, out_B, out_be, out_last, out_sew, err
    );

    modport slave (
        input  in_valid, sew, vl, data_A, data_B, out_ready,
        output in_ready, out_valid, out_A, out_B, out_be, out_last, out_sew, err
    );

endinterface

// File: rtl/sew_tail_mask.sv
// Per-byte active mask for beat k: a byte is live when its element index is below vle.
module sew_tail_mask
    import vec_mul_pkg::*;
(
    input  logic [1:0]        sew,
    input  logic [K_W-1:0]    k,
    input  logic [VL_W-1:0]   vle,
    output logic [LANE_B-1:0] be
);

    logic [VL_W-1:0] byte_idx;

    // Global byte index -> element index by SEW shift, compared against vle.
    always_comb begin
        be       = '0;
        byte_idx = '0;
        for (int unsigned j = 0; j < LANE_B; j++) begin
            byte_idx = (VL_W'(k) << LB_W) | VL_W'(j);
            be[j]    = (byte_idx >> sew) < vle;
        end
    end

endmodule

// File: rtl/sew_operand_sequencer.sv
// Streams two latched VLEN operands as LANE_W beats with tail bytes zeroed and flagged.
module sew_operand_sequencer
    import vec_mul_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    sew_operand_sequencer_if.slave bus
);

    seq_state_e        state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [VLEN-1:0]   a_q, a_d;
    logic [VLEN-1:0]   b_q, b_d;
    logic [VL_W-1:0]   vle_q, vle_d;
    logic [NB_W-1:0]   nb_q, nb_d;
    logic [1:0]        sew_q, sew_d;

    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [LANE_W-1:0] out_a_q, out_a_d;
    logic [LANE_W-1:0] out_b_q, out_b_d;
    logic [LANE_B-1:0] out_be_q, out_be_d;
    logic              out_last_q, out_last_d;
    logic              err_q, err_d;

    logic [LANE_B-1:0] be_d;
    logic [LANE_W-1:0] lane_a, lane_b;

    // Mask for the beat that will be presented next cycle.
    sew_tail_mask u_mask (
        .sew (sew_d),
        .k   (k_d),
        .vle (vle_d),
        .be  (be_d)
    );

    // Next-state: accept/latch in IDLE, advance beat index on handshake in STREAM.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        vle_d   = vle_q;
        nb_d    = nb_q;
        sew_d   = sew_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d   = bus.data_A;
                    b_d   = bus.data_B;
                    sew_d = bus.sew;
                    vle_d = (bus.vl < vlmax(bus.sew)) ? bus.vl : vlmax(bus.sew);
                    nb_d  = beats(vle_d, bus.sew);
                    k_d   = '0;
                    err_d = (bus.sew == 2'b11);
                    if (nb_d != '0) begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (bus.out_ready) begin
                    if (out_last_q) begin
                        state_d = IDLE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next registered outputs: beat k_d of the latched operands, tail bytes zeroed.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int unsigned i = 0; i < NBEATS_MAX; i++) begin
            if (K_W'(i) == k_d) begin
                lane_a = a_d[i*LANE_W +: LANE_W];
                lane_b = b_d[i*LANE_W +: LANE_W];
            end
        end
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == STREAM);
        out_last_d  = out_valid_d && (NB_W'(k_d) == (nb_d - NB_W'(1)));
        out_a_d     = '0;
        out_b_d     = '0;
        out_be_d    = '0;
        if (out_valid_d) begin
            out_be_d = be_d;
            for (int unsigned j = 0; j < LANE_B; j++) begin
                out_a_d[j*8 +: 8] = be_d[j] ? lane_a[j*8 +: 8] : 8'h00;
                out_b_d[j*8 +: 8] = be_d[j] ? lane_b[j*8 +: 8] : 8'h00;
            end
        end
    end

    // State and output registers; reset aborts any stream in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            vle_q       <= '0;
            nb_q        <= '0;
            sew_q       <= 2'b00;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_be_q    <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            vle_q       <= vle_d;
            nb_q        <= nb_d;
            sew_q       <= sew_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_be_q    <= out_be_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_A     = out_a_q;
    assign bus.out_B     = out_b_q;
    assign bus.out_be    = out_be_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sew   = sew_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_sew_operand_sequencer.sv
// Directed bench for sew_operand_sequencer (VLEN=128, LANE_W=32).
module tb_sew_operand_sequencer;
    import vec_mul_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    localparam logic [127:0] A1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] B1 = 128'hFFFEFDFC_FBFAF9F8_F7F6F5F4_F3F2F1F0;
    localparam logic [127:0] A2 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    localparam logic [127:0] B2 = 128'h1008_1007_1006_1005_1004_1003_1002_1001;
    localparam logic [127:0] A3 = 128'h44444444_33333333_22222222_11111111;

    sew_operand_sequencer_if bus ();

    sew_operand_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept at the next rising edge; returns at the first-beat sample point.
    task automatic send(input logic [1:0] s, input logic [VL_W-1:0] v,
                        input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
        bus.in_valid = 1'b1;
        bus.sew      = s;
        bus.vl       = v;
        bus.data_A   = a;
        bus.data_B   = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Check the beat currently presented, then move to the next sample point.
    task automatic beat(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [3:0] ebe, input logic el);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_A"},     bus.out_A,          ea);
        chk({tag, "_B"},     bus.out_B,          eb);
        chk({tag, "_be"},    32'(bus.out_be),    32'(ebe));
        chk({tag, "_last"},  32'(bus.out_last),  32'(el));
        chk({tag, "_rdy"},   32'(bus.in_ready),  32'd0);
        @(negedge clk);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sew       = 2'b00;
        bus.vl        = '0;
        bus.data_A    = '0;
        bus.data_B    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_A",     bus.out_A,          32'h0);
        chk("rst_out_be",    32'(bus.out_be),    32'h0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_out_sew",   32'(bus.out_sew),   32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // SEW8, full length: four full beats
        send(2'b00, VL_W'(16), A1, B1);
        chk("t1_sew", 32'(bus.out_sew), 32'd0);
        beat("t1_b0", 32'h03020100, 32'hF3F2F1F0, 4'hF, 1'b0);
        beat("t1_b1", 32'h07060504, 32'hF7F6F5F4, 4'hF, 1'b0);
        beat("t1_b2", 32'h0B0A0908, 32'hFBFAF9F8, 4'hF, 1'b0);
        beat("t1_b3", 32'h0F0E0D0C, 32'hFFFEFDFC, 4'hF, 1'b1);
        chk("t1_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_idle_ready", 32'(bus.in_ready),  32'd1);

        // SEW16, vl=3: second beat carries one live element
        send(2'b01, VL_W'(3), A2, B2);
        chk("t2_sew", 32'(bus.out_sew), 32'd1);
        beat("t2_b0", 32'h00020001, 32'h10021001, 4'hF, 1'b0);
        beat("t2_b1", 32'h00000003, 32'h00001003, 4'h3, 1'b1);
        chk("t2_idle_valid", 32'(bus.out_valid), 32'd0);

        // SEW32, vl=9 clipped to 4
        send(2'b10, VL_W'(9), A3, '0);
        beat("t3_b0", 32'h11111111, 32'h0, 4'hF, 1'b0);
        beat("t3_b1", 32'h22222222, 32'h0, 4'hF, 1'b0);
        beat("t3_b2", 32'h33333333, 32'h0, 4'hF, 1'b0);
        beat("t3_b3", 32'h44444444, 32'h0, 4'hF, 1'b1);
        chk("t3_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("t3_idle_ready", 32'(bus.in_ready),  32'd1);

        // SEW8, vl=14 with three stall cycles on beat 1
        send(2'b00, VL_W'(14), A1, B1);
        beat("t4_b0", 32'h03020100, 32'hF3F2F1F0, 4'hF, 1'b0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat("t4_stall", 32'h07060504, 32'hF7F6F5F4, 4'hF, 1'b0);
        end
        bus.out_ready = 1'b1;
        beat("t4_b1", 32'h07060504, 32'hF7F6F5F4, 4'hF, 1'b0);
        beat("t4_b2", 32'h0B0A0908, 32'hFBFAF9F8, 4'hF, 1'b0);
        beat("t4_b3", 32'h00000D0C, 32'h0000FDFC, 4'h3, 1'b1);
        chk("t4_idle_valid", 32'(bus.out_valid), 32'd0);

        // Illegal SEW then vl=0, back to back
        bus.in_valid = 1'b1;
        bus.sew      = 2'b11;
        bus.vl       = VL_W'(5);
        @(posedge clk);
        @(negedge clk);
        chk("t5_err_pulse", 32'(bus.err),       32'd1);
        chk("t5_err_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_err_ready", 32'(bus.in_ready),  32'd1);
        bus.sew = 2'b00;
        bus.vl  = '0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t5_err_drop",  32'(bus.err),       32'd0);
        chk("t5_vl0_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_vl0_ready", 32'(bus.in_ready),  32'd1);
        @(negedge clk);
        chk("t5_vl0_valid2", 32'(bus.out_valid), 32'd0);
        chk("t5_vl0_err2",   32'(bus.err),       32'd0);

        // Reset during beat 2, then a fresh single-beat operation
        send(2'b10, VL_W'(4), A3, '0);
        beat("t6_b0", 32'h11111111, 32'h0, 4'hF, 1'b0);
        beat("t6_b1", 32'h22222222, 32'h0, 4'hF, 1'b0);
        chk("t6_b2_A", bus.out_A, 32'h33333333);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_ready", 32'(bus.in_ready),  32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_post_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_post_ready", 32'(bus.in_ready),  32'd1);
        send(2'b00, VL_W'(4), A1, B1);
        beat("t6_new_b0", 32'h03020100, 32'hF3F2F1F0, 4'hF, 1'b1);
        chk("t6_end_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_end_ready", 32'(bus.in_ready),  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
